// File: rtl/hash_wfsm.sv
// Write-back FSM: captures a 512-bit Keccak digest and writes it to OCM as 128-bit
// bus-master beats. Define HASH_WFSM_BYTE_SWAP_EN to byte-reverse each 64-bit lane on capture.
module hash_wfsm #(
  parameter int MAX_BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  base_index,
  input  logic [6:0]   out_bytes,
  input  logic [511:0] hash_in,
  input  logic         hash_valid,
  input  logic         write_active,
  input  logic         write_done,
  output logic [127:0] write_data,
  output logic [31:0]  write_addr_index,
  output logic         init_master_txn,
  output logic         busy,
  output logic         done,
  output logic [31:0]  debug
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    WAIT_HASH   = 4'd1,
    LOAD        = 4'd2,
    INIT        = 4'd3,
    WAIT_ACTIVE = 4'd4,
    WAIT_DONE   = 4'd5,
    DONE        = 4'd6
  } state_t;

  state_t         state;
  logic [511:0]   hash_reg;
  logic [BW-1:0]  beats_left;
  logic [BW-1:0]  beat_num;
  logic [3:0]     tail_rem;
  logic           hash_captured;

  logic [6:0]     clamped;
  logic [6:0]     rounded;
  logic [2:0]     raw_beats;
  logic [BW-1:0]  start_beats;
  logic [3:0]     start_rem;
  logic [511:0]   captured;
  logic [127:0]   beat_raw;
  logic [127:0]   beat_masked;

  assign clamped   = (out_bytes > 7'd64) ? 7'd64 : out_bytes;
  assign rounded   = clamped + 7'd15;
  assign raw_beats = rounded[6:4];

  // The tail mask only applies when the digest's real last beat is actually written.
  always_comb begin
    if (int'(raw_beats) > MAX_BEATS) begin
      start_beats = BW'(MAX_BEATS);
      start_rem   = 4'd0;
    end else begin
      start_beats = BW'(raw_beats);
      start_rem   = clamped[3:0];
    end
  end

`ifdef HASH_WFSM_BYTE_SWAP_EN
  function automatic logic [511:0] swap_lanes(input logic [511:0] d);
    logic [511:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[64*l + 8*b +: 8] = d[64*l + 8*(7-b) +: 8];
      end
    end
    return r;
  endfunction
  assign captured = swap_lanes(hash_in);
`else
  assign captured = hash_in;
`endif

  assign beat_raw = hash_reg[int'(beat_num)*128 +: 128];

  always_comb begin
    beat_masked = beat_raw;
    if (beats_left == BW'(1) && tail_rem != 4'd0) begin
      for (int j = 0; j < 16; j++) begin
        if (4'(j) >= tail_rem) beat_masked[8*j +: 8] = 8'h00;
      end
    end
  end

  assign debug = {8'(beats_left), 8'(beat_num), 4'b0, state, 4'b0,
                  hash_captured, init_master_txn, write_active, write_done};

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      hash_reg         <= '0;
      beats_left       <= '0;
      beat_num         <= '0;
      tail_rem         <= 4'd0;
      hash_captured    <= 1'b0;
      write_data       <= '0;
      write_addr_index <= '0;
      init_master_txn  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      init_master_txn <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            beats_left       <= start_beats;
            tail_rem         <= start_rem;
            write_addr_index <= base_index;
            beat_num         <= '0;
            hash_captured    <= 1'b0;
            if (start_beats == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_HASH;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end
        WAIT_HASH: begin
          if (hash_valid) begin
            hash_reg      <= captured;
            hash_captured <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          write_data <= beat_masked;
          state      <= INIT;
        end
        INIT: begin
          init_master_txn <= 1'b1;
          state           <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          if (write_active) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (write_done) begin
            write_addr_index <= write_addr_index + 32'd1;
            beat_num         <= beat_num + BW'(1);
            beats_left       <= beats_left - BW'(1);
            if (beats_left == BW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_wfsm.sv
// Bench for hash_wfsm: directed and random digests checked against a byte-level model
// of the digest layout; honours HASH_WFSM_BYTE_SWAP_EN in the model.
module tb_hash_wfsm;

  logic         clk = 1'b0;
  logic         reset, start, hash_valid, write_active, write_done;
  logic [31:0]  base_index;
  logic [6:0]   out_bytes;
  logic [511:0] hash_in;
  logic [127:0] write_data;
  logic [31:0]  write_addr_index;
  logic         init_master_txn, busy, done;
  logic [31:0]  debug;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  addr_q[$];
  logic [127:0] first_beat;

  hash_wfsm #(.MAX_BEATS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_index(base_index),
    .out_bytes(out_bytes), .hash_in(hash_in), .hash_valid(hash_valid),
    .write_active(write_active), .write_done(write_done),
    .write_data(write_data), .write_addr_index(write_addr_index),
    .init_master_txn(init_master_txn), .busy(busy), .done(done), .debug(debug)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Digest bytes in memory order, then split into 16-byte beats with the tail zeroed.
  function automatic void build_model(input logic [31:0] base, input logic [6:0] ob,
                                      input logic [511:0] h);
    int len, nb, rem, src;
    logic [7:0]   bytes [64];
    logic [127:0] beat;
    len = (int'(ob) > 64) ? 64 : int'(ob);
    nb  = (len + 15) / 16;
    if (nb > 4) nb = 4;
    rem = len % 16;
    for (int i = 0; i < 64; i++) begin
      src = i;
`ifdef HASH_WFSM_BYTE_SWAP_EN
      src = (i / 8) * 8 + 7 - (i % 8);
`endif
      bytes[i] = h[8*src +: 8];
    end
    exp_q.delete();
    addr_q.delete();
    for (int k = 0; k < nb; k++) begin
      beat = '0;
      for (int j = 0; j < 16; j++) begin
        if (!(k == nb - 1 && rem != 0 && j >= rem)) beat[8*j +: 8] = bytes[16*k + j];
      end
      exp_q.push_back(beat);
      addr_q.push_back(base + 32'(k));
    end
  endfunction

  task automatic wait_init(output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
      write_done = 1'b0;
      if (hash_valid) begin
        hash_valid = 1'b0;
        hash_in    = rand512();
      end
    end while (init_master_txn !== 1'b1 && cnt < 30);
  endtask

  task automatic run_digest(input logic [31:0] base, input logic [6:0] ob,
                            input logic [511:0] h, input int act_dly,
                            input int done_dly, input int abort_beat);
    int cnt;
    int nb;
    logic seen;
    build_model(base, ob, h);
    nb = exp_q.size();
    base_index = base;
    out_bytes  = ob;
    start      = 1'b1;
    cyc();
    start      = 1'b0;
    if (nb == 0) begin
      check("zero_done", {done, busy}, 2'b10);
      seen = 1'b0;
      repeat (8) begin
        cyc();
        seen |= init_master_txn;
      end
      check("zero_no_txn", seen, 1'b0);
      check("zero_done_hold", done, 1'b1);
      return;
    end
    check("busy_after_start", {busy, done}, 2'b10);
    repeat ($urandom_range(0, 3)) begin
      cyc();
      check("wait_hash_idle", {busy, init_master_txn}, 2'b10);
    end
    hash_in    = h;
    hash_valid = 1'b1;
    wait_init(cnt);
    check("hash_to_init", cnt, 3);
    for (int k = 0; k < nb; k++) begin
      check("beat_data", write_data, exp_q[k]);
      check("beat_addr", write_addr_index, addr_q[k]);
      if (k == 0) first_beat = write_data;
      for (int d = 0; d < act_dly; d++) begin
        write_done = (d == 3);
        cyc();
        write_done = 1'b0;
        check("hold_wait_active", {busy, done, init_master_txn, write_data, write_addr_index},
              {1'b1, 1'b0, 1'b0, exp_q[k], addr_q[k]});
      end
      write_active = 1'b1;
      cyc();
      write_active = 1'b0;
      check("hold_accept", {busy, done, init_master_txn, write_data, write_addr_index},
            {1'b1, 1'b0, 1'b0, exp_q[k], addr_q[k]});
      if (k == abort_beat) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_reset", {write_data, write_addr_index, init_master_txn, busy, done},
              {128'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        return;
      end
      repeat (done_dly) begin
        cyc();
        check("hold_wait_done", {busy, done, init_master_txn, write_data, write_addr_index},
              {1'b1, 1'b0, 1'b0, exp_q[k], addr_q[k]});
      end
      write_done = 1'b1;
      if (k == nb - 1) begin
        cyc();
        write_done = 1'b0;
        check("final_done", {done, busy, init_master_txn}, 3'b100);
      end else begin
        wait_init(cnt);
        check("done_to_init", cnt, 3);
      end
    end
    seen = 1'b0;
    repeat (4) begin
      cyc();
      seen |= init_master_txn;
    end
    check("no_extra_txn", {seen, done}, 2'b01);
  endtask

  initial begin
    logic [511:0] inc;
    reset = 1'b1; start = 1'b0; hash_valid = 1'b0; write_active = 1'b0; write_done = 1'b0;
    base_index = '0; out_bytes = '0; hash_in = '0;
    for (int i = 0; i < 64; i++) inc[8*i +: 8] = 8'(i);
    repeat (2) cyc();
    reset = 1'b0;
    check("reset_outputs", {write_data, write_addr_index, init_master_txn, busy, done, debug[3]},
          {128'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Zero-length digest from IDLE.
    run_digest(32'h55, 7'd0, rand512(), 1, 1, -1);

    // Full digest of incrementing bytes.
    run_digest(32'h10, 7'd64, inc, 1, 1, -1);
`ifdef HASH_WFSM_BYTE_SWAP_EN
    check("first_beat_const", first_beat, 128'h08090A0B0C0D0E0F_0001020304050607);
`else
    check("first_beat_const", first_beat, 128'h0F0E0D0C0B0A0908_0706050403020100);
`endif

    // Partial tail, then a slow bus with a spurious write_done.
    run_digest(32'h200, 7'd20, rand512(), 0, 0, -1);
    run_digest(32'h1000, 7'd48, rand512(), 10, 5, -1);

    // Reset in WAIT_DONE of beat 2, then a clean restart.
    run_digest(32'h40, 7'd64, rand512(), 2, 2, 2);
    run_digest(32'h40, 7'd64, rand512(), 1, 1, -1);

    // Index wrap and over-length clamp.
    run_digest(32'hFFFF_FFFE, 7'd64, rand512(), 0, 1, -1);
    run_digest(32'h300, 7'd100, rand512(), 1, 0, -1);

    for (int r = 0; r < 8; r++) begin
      run_digest($urandom, 7'($urandom_range(0, 127)), rand512(),
                 $urandom_range(0, 6), $urandom_range(0, 6), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_wfsm.md
# hash_wfsm

Write-back FSM for the SHA3 burst master. It captures the 512-bit digest from the Keccak core when `out_ready` rises and splits it into 128-bit beats. It then launches one bus-master write transaction per beat, so the hash lands in OCM at consecutive beat indices. It is the write-direction counterpart of the read FSM that streams message words from OCM into the core.

## Interface
Parameters:
- `MAX_BEATS`, default 4: beats per digest (512/128); sets the width of the beat counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that arms the block for one digest.
- `base_index`  in  32  first beat index; sampled on `start`.
- `out_bytes`  in  7  digest length in bytes; sampled on `start`.
- `hash_in`  in  512  digest from the Keccak core.
- `hash_valid`  in  1  Keccak `out_ready`, level.
- `write_active`  in  1  bus master has accepted the transaction.
- `write_done`  in  1  bus master write response received.
- `write_data`  out  128  beat data presented to the bus master.
- `write_addr_index`  out  32  beat index of the current transaction.
- `init_master_txn`  out  1  one-cycle transaction launch pulse.
- `busy`  out  1  high from `start` until DONE.
- `done`  out  1  level; all beats written.
- `debug`  out  32  `{beats_left[7:0], beat_num[7:0], 4'b0, state[3:0], 4'b0, hash_captured, init_master_txn, write_active, write_done}`.

## Operation
- Beats: `beats = min(ceil(out_bytes/16), MAX_BEATS)`. `out_bytes = 0` gives zero beats. Values above 64 are clamped to 64 bytes.
- Beat k is taken from `hash_reg[128k+127:128k]`, k = 0 first.
- On the last beat, bytes with index ≥ `out_bytes mod 16` are driven to zero. This applies only when `out_bytes mod 16 ≠ 0`. Byte j of a beat is bits [8j+7:8j].
- States:
  - IDLE: on `start`, load `beats_left`, `write_addr_index <= base_index`, `beat_num <= 0`, then go to WAIT_HASH. If `beats = 0`, go straight to DONE.
  - WAIT_HASH: when `hash_valid` is high, `hash_reg <= hash_in`, then go to LOAD.
  - LOAD: `write_data <= beat(beat_num)` (masked), then go to INIT.
  - INIT: `init_master_txn <= 1`, then go to WAIT_ACTIVE.
  - WAIT_ACTIVE: `init_master_txn <= 0`. On `write_active`, go to WAIT_DONE.
  - WAIT_DONE: on `write_done`:
    - `write_addr_index += 1`, `beat_num += 1`, `beats_left -= 1`.
    - If `beats_left = 1`, go to DONE; else go to LOAD.
  - DONE: `done = 1`. A `start` here behaves as in IDLE and clears `done`.
- `start` is ignored in all states except IDLE and DONE.
- `write_done` is ignored outside WAIT_DONE, and `write_active` outside WAIT_ACTIVE.
- `hash_in` is sampled exactly once per digest. Later changes on `hash_in` do not affect data in flight.
- `write_addr_index` wraps modulo 2^32 with no error indication.

## Timing
- Reset values: `write_data = 0`, `write_addr_index = 0`, `init_master_txn = 0`, `busy = 0`, `done = 0`, state = IDLE, `hash_reg = 0`.
- `reset` asserted mid-transaction returns the block to IDLE next cycle. It does not wait for `write_done`; the bus master is reset by the same signal.
- From `hash_valid` high in WAIT_HASH to the first `init_master_txn` pulse: 3 cycles (capture, LOAD, INIT).
- From `write_done` to the next `init_master_txn`: 3 cycles.
- `write_data` and `write_addr_index` are stable from LOAD until the `write_done` that completes the beat.
- `init_master_txn` is high for exactly one cycle per beat.
- `done` rises on the cycle after the final `write_done`, or on the cycle after `start` when `beats = 0`.
- `busy = (state ∉ {IDLE, DONE})`. It is asserted on the cycle after `start`.

## Configuration
- `HASH_WFSM_BYTE_SWAP_EN`:
  - Defined: each 64-bit lane of `hash_in` is byte-reversed before it is captured into `hash_reg`, giving big-endian digest bytes in memory. Zero-masking applies after the swap.
  - Undefined: `hash_in` is captured unmodified, leaving Keccak lane order little-endian in memory.

## Test plan
- `out_bytes=64`, `base_index=0x10`, `hash_in` = incrementing bytes 0x00..0x3F:
  - exactly 4 `init_master_txn` pulses at indices 0x10..0x13;
  - beat 0 = `0x0F0E..0100`;
  - `done` after the 4th `write_done`.
- `out_bytes=20`: 2 beats; the second beat has bytes 4..15 equal to zero; `done` after the 2nd `write_done`.
- `out_bytes=0`: no `init_master_txn`; `done=1` one cycle after `start`.
- Bus holds `write_active` off for 10 cycles, then `write_done` 5 cycles later:
  - `write_data` and `write_addr_index` are constant throughout;
  - a spurious `write_done` during WAIT_ACTIVE is ignored.
- `reset` pulsed in WAIT_DONE of beat 2: all outputs at their reset values next cycle; a fresh `start` runs a complete 4-beat sequence from `base_index`.
- With `HASH_WFSM_BYTE_SWAP_EN` defined and lane 0 = `0x0706050403020100`: beat 0 low lane = `0x0001020304050607`.
